// File: rtl/fb_line_doubler_pkg.sv
// rtl/fb_line_doubler_pkg.sv - framebuffer geometry, XGA timing constants and fetch FSM states
package fb_line_doubler_pkg;

    localparam int FB_WIDTH  = 512;
    localparam int FB_HEIGHT = 384;
    localparam int FB_ADDRW  = 18;
    localparam int FB_XW     = $clog2(FB_WIDTH);
    localparam int FB_ROWW   = $clog2(FB_HEIGHT);

    localparam int H_RES = 1024;
    localparam int V_RES = 768;
    localparam int CORDW = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/bram_sdp.sv
// rtl/bram_sdp.sv - simple dual-port block RAM, registered read, no reset on contents
module bram_sdp #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic                     clk_write,
    input  logic                     clk_read,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr_write,
    input  logic [$clog2(DEPTH)-1:0] addr_read,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out
);

    logic [WIDTH-1:0] memory [DEPTH];

    always_ff @(posedge clk_write) begin
        if (we) memory[addr_write] <= data_in;
    end

    always_ff @(posedge clk_read) begin
        data_out <= memory[addr_read];
    end

endmodule

// File: rtl/linebuf_fetch.sv
// rtl/linebuf_fetch.sv - row prefetch FSM, framebuffer address counter and read-latency delay line
module linebuf_fetch
    import fb_line_doubler_pkg::*;
#(
    parameter int FB_RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trig,
    input  logic [FB_ROWW-1:0]  trig_row,
    output logic [FB_ADDRW-1:0] fb_addr,
    output logic                busy,
    output logic                underrun,
    output logic                wr_en,
    output logic [FB_XW:0]      wr_addr
);

    fetch_state_t       state_q, state_d;
    logic [FB_XW-1:0]   x_q, x_d;
    logic [FB_ROWW-1:0] row_q, row_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               underrun_q, underrun_d;
    logic               abort;
    logic               issue;

    logic [FB_RD_LAT-1:0] dl_valid;
    logic [FB_XW:0]       dl_addr [FB_RD_LAT];

    assign abort    = trig && (state_q != ST_IDLE);
    assign issue    = (state_q == ST_FETCH);
    assign fb_addr  = {row_q, x_q};
    assign busy     = (state_q != ST_IDLE);
    assign underrun = underrun_q;
    assign wr_en    = dl_valid[FB_RD_LAT-1];
    assign wr_addr  = dl_addr[FB_RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
        end
    end

    // An abort flushes in-flight reads so a stale row never lands in the store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_valid <= '0;
            for (int i = 0; i < FB_RD_LAT; i++) dl_addr[i] <= '0;
        end else begin
            dl_valid[0] <= issue & ~abort;
            dl_addr[0]  <= {row_q[0], x_q};
            for (int i = 1; i < FB_RD_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1] & ~abort;
                dl_addr[i]  <= dl_addr[i-1];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        underrun_d = underrun_q;
        if (trig) begin
            if (state_q != ST_IDLE) underrun_d = 1'b1;
            state_d = ST_FETCH;
            x_d     = '0;
            row_d   = trig_row;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (x_q == FB_XW'(FB_WIDTH - 1)) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == 2'(FB_RD_LAT - 1)) state_d = ST_IDLE;
                    else                            cnt_d   = cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fb_line_doubler.sv
// rtl/fb_line_doubler.sv - ping-pong line store that fetches each framebuffer row once and replays it doubled
module fb_line_doubler
    import fb_line_doubler_pkg::*;
#(
    parameter int FB_RD_LAT = 1
) (
    input  logic                    i_pix_clk,
    input  logic                    i_rst_n,
    input  logic signed [CORDW-1:0] i_sx,
    input  logic signed [CORDW-1:0] i_sy,
    input  logic                    i_de,
    input  logic                    i_hs,
    input  logic                    i_vs,
    input  logic                    i_blank,
    output logic [FB_ADDRW-1:0]     o_fb_addr,
    input  logic                    i_fb_data,
    output logic                    o_pix,
    output logic                    o_de,
    output logic                    o_hs,
    output logic                    o_vs,
    output logic                    o_busy,
    output logic                    o_underrun
);

    localparam int SXW = $clog2(H_RES);

    logic signed [CORDW:0] sy_next;
    logic                  fetch_trig;
    logic                  wr_en;
    logic [FB_XW:0]        wr_addr;
    logic [FB_XW:0]        rd_addr;
    logic                  rd_data;
    logic                  de_d1, hs_d1, vs_d1;

    // One extra bit keeps sy+1 on the last line from wrapping into range.
    assign sy_next    = {i_sy[CORDW-1], i_sy} + (CORDW+1)'(1);
    assign fetch_trig = (i_sx == '0) && (i_sy[0] || i_sy == '1)
                        && !sy_next[CORDW] && (sy_next < (CORDW+1)'(V_RES));

    // Display row sy>>1 lives in bank (sy>>1)[0]; each fb pixel covers two sx.
    assign rd_addr = {i_sy[1], i_sx[SXW-1:1]};

    linebuf_fetch #(
        .FB_RD_LAT (FB_RD_LAT)
    ) u_fetch (
        .clk      (i_pix_clk),
        .rst_n    (i_rst_n),
        .trig     (fetch_trig),
        .trig_row (sy_next[FB_ROWW:1]),
        .fb_addr  (o_fb_addr),
        .busy     (o_busy),
        .underrun (o_underrun),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr)
    );

    bram_sdp #(
        .WIDTH (1),
        .DEPTH (2*FB_WIDTH)
    ) u_store (
        .clk_write  (i_pix_clk),
        .clk_read   (i_pix_clk),
        .we         (wr_en),
        .addr_write (wr_addr),
        .addr_read  (rd_addr),
        .data_in    (i_fb_data),
        .data_out   (rd_data)
    );

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            de_d1 <= 1'b0;
            hs_d1 <= 1'b0;
            vs_d1 <= 1'b0;
            o_de  <= 1'b0;
            o_hs  <= 1'b0;
            o_vs  <= 1'b0;
            o_pix <= 1'b0;
        end else begin
            de_d1 <= i_de & ~i_blank;
            hs_d1 <= i_hs & ~i_blank;
            vs_d1 <= i_vs & ~i_blank;
            o_de  <= de_d1;
            o_hs  <= hs_d1;
            o_vs  <= vs_d1;
            o_pix <= rd_data & de_d1;
        end
    end

endmodule

// File: tb/tb_fb_line_doubler.sv
// tb/tb_fb_line_doubler.sv - scoreboard bench for fb_line_doubler at read latency 1 and 3
module tb_fb_line_doubler;
    import fb_line_doubler_pkg::*;

    localparam int LINE_LEN = 1044;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic signed [15:0] sx, sy;
    logic               de, hs, vs, blank;

    logic [17:0] addr1, addr3;
    logic        fbd1;
    logic [2:0]  fb3_pipe;
    logic        pix1, de1, hs1, vs1, busy1, und1;
    logic        pix3, de3, hs3, vs3, busy3, und3;

    fb_line_doubler #(.FB_RD_LAT(1)) dut (
        .i_pix_clk(clk), .i_rst_n(rst_n), .i_sx(sx), .i_sy(sy),
        .i_de(de), .i_hs(hs), .i_vs(vs), .i_blank(blank),
        .o_fb_addr(addr1), .i_fb_data(fbd1),
        .o_pix(pix1), .o_de(de1), .o_hs(hs1), .o_vs(vs1),
        .o_busy(busy1), .o_underrun(und1)
    );

    fb_line_doubler #(.FB_RD_LAT(3)) dut3 (
        .i_pix_clk(clk), .i_rst_n(rst_n), .i_sx(sx), .i_sy(sy),
        .i_de(de), .i_hs(hs), .i_vs(vs), .i_blank(blank),
        .o_fb_addr(addr3), .i_fb_data(fb3_pipe[2]),
        .o_pix(pix3), .o_de(de3), .o_hs(hs3), .o_vs(vs3),
        .o_busy(busy3), .o_underrun(und3)
    );

    typedef struct {
        int   due;
        logic de;
        logic hs;
        logic vs;
        logic pix;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic fb_pixel(input int x, input int y);
        return x[0] ^ y[0] ^ x[3] ^ x[7] ^ y[2];
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        fbd1     <= fb_pixel(int'(addr1[8:0]), int'(addr1[17:9]));
        fb3_pipe <= {fb3_pipe[1:0], fb_pixel(int'(addr3[8:0]), int'(addr3[17:9]))};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("o_de",       32'(de1),  32'(e.de));
            chk("o_hs",       32'(hs1),  32'(e.hs));
            chk("o_vs",       32'(vs1),  32'(e.vs));
            chk("o_pix",      32'(pix1), 32'(e.pix));
            chk("o_de_lat3",  32'(de3),  32'(e.de));
            chk("o_hs_lat3",  32'(hs3),  32'(e.hs));
            chk("o_vs_lat3",  32'(vs3),  32'(e.vs));
            chk("o_pix_lat3", 32'(pix3), 32'(e.pix));
        end
    end

    task automatic run_cycle(input int x, input int y, input bit d, input bit h,
                             input bit v, input bit blk, input int row);
        exp_t e;
        @(posedge clk);
        #1;
        sx    = 16'(x);
        sy    = 16'(y);
        de    = d;
        hs    = h;
        vs    = v;
        blank = blk;
        e.due = cyc + 2;
        e.de  = d & ~blk;
        e.hs  = h & ~blk;
        e.vs  = v & ~blk;
        e.pix = e.de ? fb_pixel(x >> 1, row) : 1'b0;
        sb.push_back(e);
    endtask

    task automatic drive_line(input int y, input int de_lo, input int exp_row,
                              input bit blk, input int chk_row);
        bit trig;
        trig = ((y % 2) != 0 || y == -1) && (y + 1 >= 0) && (y + 1 < V_RES);
        for (int x = 0; x < LINE_LEN; x++) begin
            run_cycle(x, y, (de_lo >= 0) && (x >= de_lo) && (x < H_RES),
                      (x >= 1030) && (x < 1040), y < 0, blk, exp_row);
            if (chk_row >= 0 && x >= 1 && x <= 512) begin
                @(negedge clk);
                chk("fetch_addr",      32'(addr1), 32'({chk_row[8:0], 9'(x - 1)}));
                chk("fetch_addr_lat3", 32'(addr3), 32'({chk_row[8:0], 9'(x - 1)}));
            end else if (x inside {0, 1, 10, 513, 514, 515, 516, 600}) begin
                @(negedge clk);
                chk("busy",      32'(busy1), 32'(trig && x >= 1 && x <= 513));
                chk("busy_lat3", 32'(busy3), 32'(trig && x >= 1 && x <= 515));
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix"},  32'({pix1, pix3}),   32'd0);
        chk({tag, "_de"},   32'({de1, de3}),     32'd0);
        chk({tag, "_hs"},   32'({hs1, hs3}),     32'd0);
        chk({tag, "_vs"},   32'({vs1, vs3}),     32'd0);
        chk({tag, "_busy"}, 32'({busy1, busy3}), 32'd0);
        chk({tag, "_und"},  32'({und1, und3}),   32'd0);
        chk({tag, "_addr"}, 32'(addr1),          32'd0);
        chk({tag, "_addr3"}, 32'(addr3),         32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        sx = '0; sy = '0; de = 1'b0; hs = 1'b0; vs = 1'b0; blank = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        drive_line(-1, -1, 0, 1'b0, 0);
        drive_line(0, 0, 0, 1'b0, -1);
        drive_line(1, 0, 0, 1'b0, 1);
        drive_line(2, 0, 1, 1'b0, -1);
        drive_line(3, 0, 1, 1'b0, -1);
        drive_line(4, 0, 2, 1'b0, -1);
        drive_line(5, 0, 2, 1'b1, -1);
        drive_line(6, 0, 3, 1'b0, -1);

        for (int x = 0; x < 100; x++) begin
            run_cycle(x, 7, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            if (x == 50) begin
                @(negedge clk);
                chk("underrun_pre", 32'({und1, und3}), 32'd0);
            end
        end
        run_cycle(0, 9, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int x = 1; x < LINE_LEN; x++) begin
            run_cycle(x, 9, 1'b0, (x >= 1030) && (x < 1040), 1'b0, 1'b0, 0);
            if (x <= 3) begin
                @(negedge clk);
                chk("underrun_set", 32'({und1, und3}), 32'b11);
                chk("restart_addr",      32'(addr1), 32'({9'd5, 9'(x - 1)}));
                chk("restart_addr_lat3", 32'(addr3), 32'({9'd5, 9'(x - 1)}));
            end
        end
        drive_line(10, 0, 5, 1'b0, -1);
        @(negedge clk);
        chk("underrun_sticky", 32'({und1, und3}), 32'b11);

        for (int x = 0; x < 202; x++) run_cycle(x, 11, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("abort_addr",      32'(addr1), 32'({9'd6, 9'd200}));
        chk("abort_addr_lat3", 32'(addr3), 32'({9'd6, 9'd200}));
        #1 rst_n = 1'b0;
        sb.delete();
        #1 chk_all_zero("rst_async");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive_line(12, 512, 2, 1'b0, -1);
        drive_line(13, -1, 0, 1'b0, -1);
        drive_line(14, 0, 7, 1'b0, -1);

        drive_line(763, -1, 0, 1'b0, -1);
        drive_line(764, 0, 382, 1'b0, -1);
        drive_line(765, 0, 382, 1'b0, -1);
        drive_line(766, 0, 383, 1'b0, -1);
        drive_line(767, 0, 383, 1'b0, -1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
